// File: rtl/hacd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hacd_pkg
// Desc     : Shared types and defaults for the Hawk AXI read arbiter.
// Revision : 1.0
// ============================================================================
package hacd_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int OSTD_DEPTH_DEF = 8;

endpackage
`default_nettype wire

// File: rtl/hawk_axird_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : hawk_axird_arb_if
// Desc     : AXI4 AR/R bundle; NUM_MSTR lanes of AR valid/ready, shared R data.
// Revision : 1.0
// ============================================================================
interface hawk_axird_arb_if #(
    parameter int NUM_MSTR = 1,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 512,
    parameter int ID_W     = 6,
    parameter int LEN_W    = 8
);
    logic [NUM_MSTR-1:0]        arvalid;
    logic [NUM_MSTR-1:0]        arready;
    logic [NUM_MSTR*ADDR_W-1:0] araddr;
    logic [NUM_MSTR*ID_W-1:0]   arid;
    logic [NUM_MSTR*LEN_W-1:0]  arlen;
    logic [NUM_MSTR-1:0]        rvalid;
    logic [NUM_MSTR-1:0]        rready;
    logic [DATA_W-1:0]          rdata;
    logic [ID_W-1:0]            rid;
    logic [1:0]                 rresp;
    logic                       rlast;

    modport master (
        output arvalid, araddr, arid, arlen, rready,
        input  arready, rvalid, rdata, rid, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, rready,
        output arready, rvalid, rdata, rid, rresp, rlast
    );
endinterface
`default_nettype wire

// File: rtl/hawk_arb_order_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hawk_arb_order_fifo
// Desc     : Synchronous FIFO, extra-MSB pointers; push accepted when full if popping.
// Revision : 1.0
// ============================================================================
module hawk_arb_order_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_ni,
    input  wire logic                   push,
    input  wire logic [WIDTH-1:0]       push_data,
    input  wire logic                   pop,
    output logic      [WIDTH-1:0]       pop_data,
    output logic                        full,
    output logic                        empty,
    output logic      [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count     = r_wr_ptr - r_rd_ptr;
    assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_pop  = pop & ~empty;
    // When full, the slot being written is the head being popped this cycle.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end
endmodule
`default_nettype wire

// File: rtl/hawk_axird_arb.sv
`default_nettype none
// ============================================================================
// Module   : hawk_axird_arb
// Desc     : N-master AXI4 read arbiter, registered AR slice, in-order R routing.
// Revision : 1.0
// ============================================================================
module hawk_axird_arb
    import hacd_pkg::*;
#(
    parameter int NUM_MSTR   = 2,
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 512,
    parameter int ID_W       = 6,
    parameter int LEN_W      = 8,
    parameter int OSTD_DEPTH = OSTD_DEPTH_DEF,
    parameter int ARB_MODE   = 1
) (
    input  wire logic                          clk_i,
    input  wire logic                          rst_ni,
    hawk_axird_arb_if.slave                    s,
    hawk_axird_arb_if.master                   m,
    input  wire logic [NUM_MSTR-1:0]           excl_mask,
    output logic      [$clog2(OSTD_DEPTH):0]   ostd_cnt,
    output logic                               orphan_err
);
    localparam int        IDX_W = (NUM_MSTR > 1) ? $clog2(NUM_MSTR) : 1;
    localparam arb_mode_e MODE  = arb_mode_e'(ARB_MODE[0]);

    logic              r_arvalid;
    logic [ADDR_W-1:0] r_araddr;
    logic [ID_W-1:0]   r_arid;
    logic [LEN_W-1:0]  r_arlen;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic              r_orphan;

    logic [NUM_MSTR-1:0] w_eligible;
    logic                w_found;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic [IDX_W-1:0]    w_idx;
    logic                w_grant;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [IDX_W-1:0]    w_head;
    logic                w_mrready;
    logic                w_pop;
    logic [DATA_W-1:0]   w_rdata;

    assign w_eligible = s.arvalid & ~excl_mask;

    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        for (int k = 0; k < NUM_MSTR; k++) begin
            if (MODE == ARB_RR) w_idx = IDX_W'((int'(r_rr_ptr) + k) % NUM_MSTR);
            else                w_idx = IDX_W'(k);
            if (!w_found && w_eligible[w_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
    end

    // A grant needs room in the slice and an order slot (a retiring burst frees one).
    assign w_grant   = w_found && (!r_arvalid || m.arready) && (!w_fifo_full || w_pop);
    assign s.arready = w_grant ? (NUM_MSTR'(1) << w_gnt_idx) : '0;

    assign m.arvalid = r_arvalid;
    assign m.araddr  = r_araddr;
    assign m.arid    = r_arid;
    assign m.arlen   = r_arlen;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arid    <= '0;
            r_arlen   <= '0;
            r_rr_ptr  <= '0;
            r_orphan  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_arvalid <= 1'b1;
                r_araddr  <= s.araddr[w_gnt_idx*ADDR_W +: ADDR_W];
                r_arid    <= s.arid[w_gnt_idx*ID_W +: ID_W];
                r_arlen   <= s.arlen[w_gnt_idx*LEN_W +: LEN_W];
                r_rr_ptr  <= (w_gnt_idx == IDX_W'(NUM_MSTR-1)) ? '0 : w_gnt_idx + 1'b1;
            end else if (m.arready) begin
                r_arvalid <= 1'b0;
            end
            if (m.rvalid && w_fifo_empty) r_orphan <= 1'b1;
        end
    end

    hawk_arb_order_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (OSTD_DEPTH)
    ) u_order_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (w_grant),
        .push_data (w_gnt_idx),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (ostd_cnt)
    );

    // Beats always belong to the oldest granted burst; the head retires on rlast.
    assign w_mrready = s.rready[w_head] & ~w_fifo_empty;
    assign w_pop     = m.rvalid & w_mrready & m.rlast;
    assign m.rready  = w_mrready;
    assign s.rvalid  = (m.rvalid && !w_fifo_empty) ? (NUM_MSTR'(1) << w_head) : '0;

    assign w_rdata    = m.rdata;
    assign s.rdata    = w_rdata;
    assign s.rid      = m.rid;
    assign s.rresp    = m.rresp;
    assign s.rlast    = m.rlast;
    assign orphan_err = r_orphan;
endmodule
`default_nettype wire

// File: tb/tb_hawk_axird_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_hawk_axird_arb
// Desc     : Scoreboard bench for hawk_axird_arb (round-robin DUT plus fixed-priority twin).
// Revision : 1.0
// ============================================================================
module tb_hawk_axird_arb;
    typedef struct {
        logic [63:0] addr;
        logic [5:0]  id;
        logic [7:0]  len;
    } ar_t;
    typedef struct {
        int          mstr;
        logic [63:0] data;
    } r_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] excl = 2'b00;
    logic [3:0] ostd;
    logic       orphan;
    logic [3:0] ostd_fx;
    logic       orphan_fx;
    int         n_cmp = 0;
    int         n_err = 0;
    ar_t        q_ar[$];
    r_t         q_r[$];

    always #5 clk = ~clk;

    hawk_axird_arb_if #(.NUM_MSTR(2)) u_rr ();
    hawk_axird_arb_if #(.NUM_MSTR(1)) d_rr ();
    hawk_axird_arb_if #(.NUM_MSTR(2)) u_fx ();
    hawk_axird_arb_if #(.NUM_MSTR(1)) d_fx ();

    hawk_axird_arb #(.NUM_MSTR(2), .ARB_MODE(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .s(u_rr), .m(d_rr),
        .excl_mask(excl), .ostd_cnt(ostd), .orphan_err(orphan)
    );
    hawk_axird_arb #(.NUM_MSTR(2), .ARB_MODE(0)) dut_fx (
        .clk_i(clk), .rst_ni(rst_n), .s(u_fx), .m(d_fx),
        .excl_mask(2'b00), .ostd_cnt(ostd_fx), .orphan_err(orphan_fx)
    );

    assign u_fx.arvalid = u_rr.arvalid;
    assign u_fx.araddr  = u_rr.araddr;
    assign u_fx.arid    = u_rr.arid;
    assign u_fx.arlen   = u_rr.arlen;
    assign u_fx.rready  = 2'b11;
    assign d_fx.arready = 1'b1;
    assign d_fx.rvalid  = 1'b0;
    assign d_fx.rdata   = '0;
    assign d_fx.rid     = '0;
    assign d_fx.rresp   = '0;
    assign d_fx.rlast   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int mi, input logic [63:0] addr, input logic [5:0] id,
                           input logic [7:0] len);
        u_rr.araddr[mi*64 +: 64] = addr;
        u_rr.arid[mi*6 +: 6]     = id;
        u_rr.arlen[mi*8 +: 8]    = len;
    endtask

    task automatic beat(input logic [63:0] data, input logic last);
        d_rr.rvalid = 1'b1;
        d_rr.rdata  = {448'b0, data};
        d_rr.rlast  = last;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        u_rr.arvalid = '0; u_rr.rready = '0; excl = '0;
        d_rr.arready = 1'b0; d_rr.rvalid = 1'b0; d_rr.rlast = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares every downstream AR and upstream R handshake against the queues.
    always @(negedge clk) begin
        #2;
        if (d_rr.arvalid && d_rr.arready) begin
            if (q_ar.size() == 0) chk("ar_unexpected", 1, 0);
            else begin
                ar_t e;
                e = q_ar.pop_front();
                chk("ar_addr", d_rr.araddr, e.addr);
                chk("ar_id", 64'(d_rr.arid), 64'(e.id));
                chk("ar_len", 64'(d_rr.arlen), 64'(e.len));
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (u_rr.rvalid[i] && u_rr.rready[i]) begin
                if (q_r.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    r_t e;
                    e = q_r.pop_front();
                    chk("r_mstr", 64'(i), 64'(e.mstr));
                    chk("r_data", u_rr.rdata[63:0], e.data);
                end
            end
        end
    end

    initial begin
        int bt;
        int cyc;
        int em;
        u_rr.arvalid = '0; u_rr.araddr = '0; u_rr.arid = '0; u_rr.arlen = '0; u_rr.rready = '0;
        d_rr.arready = 1'b0; d_rr.rvalid = 1'b0; d_rr.rdata = '0; d_rr.rid = '0;
        d_rr.rresp = '0; d_rr.rlast = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m_arvalid", 64'(d_rr.arvalid), 0);
        chk("rst_s_arready", 64'(u_rr.arready), 0);
        chk("rst_s_rvalid", 64'(u_rr.rvalid), 0);
        chk("rst_m_rready", 64'(d_rr.rready), 0);
        chk("rst_ostd", 64'(ostd), 0);
        chk("rst_orphan", 64'(orphan), 0);
        rst_n = 1'b1;

        // Single read from master 1
        @(negedge clk);
        set_req(1, 64'h1000, 6'd5, 8'd0);
        u_rr.arvalid = 2'b10;
        q_ar.push_back('{64'h1000, 6'd5, 8'd0});
        #1 chk("t1_arready", 64'(u_rr.arready), 64'h2);
        @(negedge clk);
        u_rr.arvalid = '0;
        d_rr.arready = 1'b1;
        #1;
        chk("t1_m_arvalid", 64'(d_rr.arvalid), 1);
        chk("t1_m_araddr", d_rr.araddr, 64'h1000);
        chk("t1_ostd_1", 64'(ostd), 1);
        @(negedge clk);
        u_rr.rready = 2'b11;
        beat(64'hABCD, 1'b1);
        q_r.push_back('{1, 64'hABCD});
        #1;
        chk("t1_m_arvalid_drained", 64'(d_rr.arvalid), 0);
        chk("t1_s_rvalid", 64'(u_rr.rvalid), 64'h2);
        chk("t1_m_rready", 64'(d_rr.rready), 1);
        @(negedge clk);
        d_rr.rvalid = 1'b0;
        #1 chk("t1_ostd_0", 64'(ostd), 0);

        // Both masters continuously valid: RR alternates, fixed always picks 0
        do_reset();
        @(negedge clk);
        set_req(0, 64'hA000, 6'd1, 8'd0);
        set_req(1, 64'hB000, 6'd2, 8'd0);
        u_rr.arvalid = 2'b11;
        d_rr.arready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            em = c % 2;
            q_ar.push_back(em == 0 ? '{64'hA000, 6'd1, 8'd0} : '{64'hB000, 6'd2, 8'd0});
            #1;
            chk("t2_rr_grant", 64'(u_rr.arready), 64'(1 << em));
            chk("t2_fx_grant", 64'(u_fx.arready), 64'h1);
            @(negedge clk);
        end
        u_rr.arvalid = '0;
        u_rr.rready = 2'b11;
        for (int c = 0; c < 4; c++) begin
            beat(64'h200 + 64'(c), 1'b1);
            q_r.push_back('{c % 2, 64'h200 + 64'(c)});
            @(negedge clk);
        end
        d_rr.rvalid = 1'b0;
        #1 chk("t2_ostd_0", 64'(ostd), 0);

        // Exclusion mask blocks master 0 until released
        do_reset();
        @(negedge clk);
        set_req(0, 64'hA000, 6'd1, 8'd0);
        set_req(1, 64'hB000, 6'd2, 8'd0);
        u_rr.arvalid = 2'b11;
        d_rr.arready = 1'b1;
        excl = 2'b01;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) excl = 2'b00;
            em = (c == 2) ? 0 : 1;
            q_ar.push_back(em == 0 ? '{64'hA000, 6'd1, 8'd0} : '{64'hB000, 6'd2, 8'd0});
            #1 chk("t3_mask_grant", 64'(u_rr.arready), 64'(1 << em));
            @(negedge clk);
        end
        u_rr.arvalid = '0;
        u_rr.rready = 2'b11;
        for (int c = 0; c < 3; c++) begin
            beat(64'h300 + 64'(c), 1'b1);
            q_r.push_back('{(c == 2) ? 0 : 1, 64'h300 + 64'(c)});
            @(negedge clk);
        end
        d_rr.rvalid = 1'b0;

        // Fill the order FIFO, then pop and push in the same cycle
        do_reset();
        @(negedge clk);
        d_rr.arready = 1'b1;
        u_rr.arvalid = 2'b01;
        for (int c = 0; c < 8; c++) begin
            set_req(0, 64'h4000 + 64'(c * 64), 6'(c), 8'd0);
            q_ar.push_back('{64'h4000 + 64'(c * 64), 6'(c), 8'd0});
            #1 chk("t4_fill_grant", 64'(u_rr.arready), 64'h1);
            @(negedge clk);
        end
        set_req(0, 64'h5000, 6'd9, 8'd0);
        #1;
        chk("t4_full_arready", 64'(u_rr.arready), 0);
        chk("t4_full_ostd", 64'(ostd), 8);
        @(negedge clk);
        u_rr.rready = 2'b01;
        beat(64'h400, 1'b1);
        q_r.push_back('{0, 64'h400});
        q_ar.push_back('{64'h5000, 6'd9, 8'd0});
        #1;
        chk("t4_pop_push_grant", 64'(u_rr.arready), 64'h1);
        chk("t4_pop_rready", 64'(d_rr.rready), 1);
        @(negedge clk);
        u_rr.arvalid = '0;
        d_rr.rvalid = 1'b0;
        #1 chk("t4_ostd_hold", 64'(ostd), 8);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            beat(64'h410 + 64'(c), 1'b1);
            q_r.push_back('{0, 64'h410 + 64'(c)});
        end
        @(negedge clk);
        d_rr.rvalid = 1'b0;
        #1 chk("t4_ostd_0", 64'(ostd), 0);

        // Four-beat burst to master 0 under backpressure, then one beat to master 1
        do_reset();
        @(negedge clk);
        d_rr.arready = 1'b1;
        set_req(0, 64'hC000, 6'd3, 8'd3);
        u_rr.arvalid = 2'b01;
        q_ar.push_back('{64'hC000, 6'd3, 8'd3});
        @(negedge clk);
        set_req(1, 64'hD000, 6'd4, 8'd0);
        u_rr.arvalid = 2'b10;
        q_ar.push_back('{64'hD000, 6'd4, 8'd0});
        #1 chk("t5_grant_m1", 64'(u_rr.arready), 64'h2);
        @(negedge clk);
        u_rr.arvalid = '0;
        bt = 0;
        cyc = 0;
        while (bt < 5 && cyc < 40) begin
            @(negedge clk);
            em = (bt < 4) ? 0 : 1;
            u_rr.rready = {1'b1, cyc[0]};
            beat(64'h500 + 64'(bt), (bt == 3 || bt == 4));
            #1;
            chk("t5_bp_rready", 64'(d_rr.rready), 64'(u_rr.rready[em]));
            chk("t5_route", 64'(u_rr.rvalid), 64'(1 << em));
            if (u_rr.rready[em]) begin
                q_r.push_back('{em, 64'h500 + 64'(bt)});
                bt++;
            end
            cyc++;
        end
        chk("t5_beats", 64'(bt), 5);
        @(negedge clk);
        d_rr.rvalid = 1'b0;
        d_rr.rlast = 1'b0;

        // Orphan beat with nothing outstanding
        do_reset();
        @(negedge clk);
        u_rr.rready = 2'b11;
        beat(64'h600, 1'b1);
        #1;
        chk("t6_m_rready", 64'(d_rr.rready), 0);
        chk("t6_s_rvalid", 64'(u_rr.rvalid), 0);
        @(negedge clk);
        d_rr.rvalid = 1'b0;
        #1 chk("t6_orphan_set", 64'(orphan), 1);
        repeat (3) @(negedge clk);
        #1 chk("t6_orphan_held", 64'(orphan), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("t6_orphan_cleared", 64'(orphan), 0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (2) @(negedge clk);
        chk("ar_queue_drained", 64'(q_ar.size()), 0);
        chk("r_queue_drained", 64'(q_r.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
